// File: rtl/aes128_decrypt_iter_if.sv
// Request/response bundle for the iterative AES-128 decrypt core.
interface aes128_decrypt_iter_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] cipher_in;
  logic         busy;
  logic         done;
  logic [127:0] plain_out;

  modport master (
    output start, key_in, cipher_in,
    input  busy, done, plain_out
  );

  modport slave (
    input  start, key_in, cipher_in,
    output busy, done, plain_out
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher. The key is expanded forward to rk10, then
// one decryption round runs per clock while the key schedule is walked back
// from rk10 to rk0 on the fly. Optional single-entry cache of key -> rk10.
module aes128_decrypt_iter #(
  parameter int unsigned KEY_CACHE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  aes128_decrypt_iter_if.slave bus
);

  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo key_fwd: recover columns 3..1 by xor with the neighbour, then column 0
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, w0, w1, w2, w3;
    {n0, n1, n2, n3} = k;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_rot(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (09, 0b, 0d, 0e)
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  // Row r rotates right by r columns
  function automatic blk_t inv_shift_sub(input blk_t s);
    blk_t o;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[4'(4 * c + r)] = INV_SBOX[s[4'(4 * ((c + 4 - r) % 4) + r)]];
      end
    end
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[4'(4 * c)];
      a1 = s[4'(4 * c + 1)];
      a2 = s[4'(4 * c + 2)];
      a3 = s[4'(4 * c + 3)];
      o[4'(4 * c)]     = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[4'(4 * c + 1)] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[4'(4 * c + 2)] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[4'(4 * c + 3)] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] rk_q, rk_d;
  blk_t         st_q, st_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] plain_q, plain_d;
  logic [127:0] ckey_q, ckey_d;
  logic [127:0] crk_q, crk_d;
  logic         cvld_q, cvld_d;

  logic [127:0] rk_next;
  logic [127:0] rk_prev;
  blk_t         sub_out;
  logic         cache_hit;

  // Key schedule steps and shared inverse round datapath
  always_comb begin
    rk_next   = key_fwd(rk_q, rcon(r_q));
    rk_prev   = key_inv(rk_q, rcon(r_q + 4'd1));
    sub_out   = inv_shift_sub(st_q);
    cache_hit = (KEY_CACHE != 0) && cvld_q && (bus.key_in == ckey_q);
  end

  // Next-state logic for the control FSM and the datapath registers
  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    rk_d    = rk_q;
    st_d    = st_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plain_d = plain_q;
    ckey_d  = ckey_q;
    crk_d   = crk_q;
    cvld_d  = cvld_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (cache_hit) begin
            rk_d  = crk_q;
            st_d  = bus.cipher_in ^ crk_q;
            r_d   = 4'd9;
            fsm_d = ROUND;
          end else begin
            rk_d  = bus.key_in;
            st_d  = bus.cipher_in;
            r_d   = 4'd1;
            fsm_d = KEYEXP;
            // Key is latched into the cache here (entry marked invalid) so the
            // core needs no separate copy of key_in during expansion.
            if (KEY_CACHE != 0) begin
              ckey_d = bus.key_in;
              cvld_d = 1'b0;
            end
          end
        end
      end
      KEYEXP: begin
        rk_d = rk_next;
        if (r_q == 4'd10) begin
          st_d  = st_q ^ rk_next;
          r_d   = 4'd9;
          fsm_d = ROUND;
          if (KEY_CACHE != 0) begin
            crk_d  = rk_next;
            cvld_d = 1'b1;
          end
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      ROUND: begin
        st_d = inv_mix_columns(sub_out ^ rk_prev);
        rk_d = rk_prev;
        r_d  = r_q - 4'd1;
        if (r_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        plain_d = sub_out ^ rk_prev;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      r_q     <= '0;
      rk_q    <= '0;
      st_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plain_q <= '0;
      ckey_q  <= '0;
      crk_q   <= '0;
      cvld_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      rk_q    <= rk_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plain_q <= plain_d;
      ckey_q  <= ckey_d;
      crk_q   <= crk_d;
      cvld_q  <= cvld_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.plain_out = plain_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed + random checks of aes128_decrypt_iter (cached and uncached) against
// a textbook AES-128 inverse cipher with a fully precomputed key schedule.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ABK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ABC = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ABP = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  aes128_decrypt_iter_if if0 ();
  aes128_decrypt_iter_if if1 ();

  aes128_decrypt_iter #(.KEY_CACHE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  aes128_decrypt_iter #(.KEY_CACHE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x};
    return t[15 - n -: 8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) w[i] = key[127 - 8 * i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4 * (i - 1) + j];
      if (i % 4 == 0) begin
        a0 = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[a0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4 * i + j] = w[4 * (i - 4) + j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8 * i -: 8] ^ w[160 + i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4 * c + r] = isb[s[4 * ((c - r + 4) % 4) + r]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16 * rnd + i];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4 * c + 1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4 * c + 2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4 * c + 3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? if0.done : if1.done;
  endfunction

  function automatic logic [127:0] get_plain(input int d);
    return (d == 0) ? if0.plain_out : if1.plain_out;
  endfunction

  task automatic drive(input int d, input logic s, input logic [127:0] k, input logic [127:0] c);
    if (d == 0) begin
      if0.start = s; if0.key_in = k; if0.cipher_in = c;
    end else begin
      if1.start = s; if1.key_in = k; if1.cipher_in = c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One decryption: start pulse, bounded wait for done, latency/busy/result checks
  task automatic run_dec(input int d, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] exp, input int exp_lat, input bit repulse,
                         input string tag);
    int lat, busy_cnt, extra_done;
    drive(d, 1'b1, key, ct);
    step();
    lat = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      if (get_busy(d)) busy_cnt++;
      drive(d, repulse && (lat == 3 || lat == 15), rnd128(), rnd128());
      step();
      lat++;
      if (get_done(d)) break;
    end
    drive(d, 1'b0, rnd128(), rnd128());
    check_int({tag, " latency"}, lat, exp_lat);
    check128({tag, " plain"}, get_plain(d), exp);
    check_int({tag, " busy cycles"}, busy_cnt, exp_lat);
    check_int({tag, " busy at done"}, int'(get_busy(d)), 0);
    extra_done = 0;
    for (int i = 0; i < (repulse ? 25 : 1); i++) begin
      step();
      if (get_done(d)) extra_done++;
    end
    check_int({tag, " extra done"}, extra_done, 0);
    check128({tag, " plain held"}, get_plain(d), exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, held, nd;
    logic [127:0] k, c;
    build_sbox();
    reset = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    step();
    step();
    check_int("reset busy0", int'(if0.busy), 0);
    check_int("reset done0", int'(if0.done), 0);
    check128("reset plain0", if0.plain_out, '0);
    check_int("reset busy1", int'(if1.busy), 0);
    check128("reset plain1", if1.plain_out, '0);
    reset = 1'b0;

    run_dec(0, C1K, C1C, C1P, 20, 1'b0, "C.1");
    run_dec(0, ABK, ABC, ABP, 20, 1'b0, "AppB");
    run_dec(0, C1K, C1C, C1P, 20, 1'b1, "C.1 repulse");

    // Abort mid-run with reset
    drive(0, 1'b1, C1K, C1C);
    step();
    drive(0, 1'b0, rnd128(), rnd128());
    repeat (12) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_int("abort busy", int'(if0.busy), 0);
    check_int("abort done", int'(if0.done), 0);
    check128("abort plain", if0.plain_out, '0);
    nd = 0;
    repeat (25) begin
      step();
      if (if0.done) nd++;
    end
    check_int("abort no late done", nd, 0);
    run_dec(0, C1K, C1C, C1P, 20, 1'b0, "C.1 after reset");

    // Back-to-back with start held high
    drive(0, 1'b1, C1K, C1C);
    step();
    drive(0, 1'b1, ABK, ABC);
    lat = 0;
    while (lat < 40) begin
      step();
      lat++;
      if (if0.done) break;
    end
    check_int("b2b first latency", lat, 20);
    check128("b2b first plain", if0.plain_out, C1P);
    step();
    drive(0, 1'b0, rnd128(), rnd128());
    check_int("b2b second accepted", int'(if0.busy), 1);
    held = 1;
    lat = 0;
    while (lat < 40) begin
      if (if0.plain_out !== C1P) held = 0;
      step();
      lat++;
      if (if0.done) break;
    end
    check_int("b2b plain held", held, 1);
    check_int("b2b second latency", lat, 20);
    check128("b2b second plain", if0.plain_out, ABP);
    step();

    // Random vectors, uncached core
    for (int i = 0; i < 4; i++) begin
      k = rnd128();
      c = rnd128();
      run_dec(0, k, c, ref_decrypt(k, c), 20, 1'b0, "rand full");
    end
    // Uncached core never shortcuts a repeated key
    c = rnd128();
    run_dec(0, k, c, ref_decrypt(k, c), 20, 1'b0, "nocache repeat key");

    // Key cache
    run_dec(1, C1K, C1C, C1P, 20, 1'b0, "cache miss C.1");
    c = rnd128();
    run_dec(1, C1K, c, ref_decrypt(C1K, c), 10, 1'b0, "cache hit C.1 key");
    run_dec(1, ABK, ABC, ABP, 20, 1'b0, "cache new key");
    run_dec(1, ABK, ABC, ABP, 10, 1'b0, "cache hit AppB");
    k = rnd128();
    c = rnd128();
    run_dec(1, k, c, ref_decrypt(k, c), 20, 1'b0, "cache rand miss");
    c = rnd128();
    run_dec(1, k, c, ref_decrypt(k, c), 10, 1'b0, "cache rand hit");
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_dec(1, k, c, ref_decrypt(k, c), 20, 1'b0, "cache after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
